// File: rtl/rib_resp.sv
// rib_resp: bus responder with a local word array and a fixed hold delay.
// Optional macro RIB_RESP_ERR_EN adds address range checking and err_o.
module rib_resp #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hold_flag_o
`ifdef RIB_RESP_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam bit          ZW = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        hold;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic        rd_act;
    logic        wr_act;
    logic        wr_en;

`ifdef RIB_RESP_ERR_EN
    localparam logic [32:0] LIMIT =
        {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
    logic addr_err;
    logic err_q;
`endif

    // Select the live request (zero-wait) or the captured one, and decode it
    always_comb begin
        eff_addr  = ZW ? addr_i : addr_q;
        eff_wdata = ZW ? data_i : wdata_q;
        offset    = eff_addr - BASE_ADDR;
        idx       = AW'(offset >> 2);
        rd_word   = mem_q[idx];
        rd_act    = rst && (ZW ? (req_i && !we_i)
                                : (state_q == DONE && !we_q));
        wr_act    = rst && (ZW ? (req_i && we_i)
                                : (state_q == DONE && we_q));
`ifdef RIB_RESP_ERR_EN
        addr_err  = (eff_addr < BASE_ADDR)
                 || ({1'b0, eff_addr} >= LIMIT);
        wr_en     = wr_act && !addr_err;
        if (!rd_act) begin
            data_o = 32'h0;
        end else if (addr_err) begin
            data_o = 32'hDEAD_BEEF;
        end else begin
            data_o = rd_word;
        end
`else
        wr_en     = wr_act;
        data_o    = rd_act ? rd_word : 32'h0;
`endif
    end

    // Next-state logic: accept in IDLE, count hold cycles in WAIT, finish in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        hold    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i && !ZW) begin
                    hold    = 1'b1;
                    addr_d  = addr_i;
                    we_d    = we_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                hold = 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        hold_flag_o = hold && rst;
    end

    // State, counter and captured request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= eff_wdata;
        end
    end

`ifdef RIB_RESP_ERR_EN
    // Sticky error flag, set by any completed access to an out-of-range address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((rd_act || wr_act) && addr_err) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_rib_resp.sv
// tb_rib_resp: scoreboard bench for rib_resp at WAIT_CYCLES 0, 2 and 3.
// Honours RIB_RESP_ERR_EN to exercise the address error feature.
module tb_rib_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req0, req2, req3;
    logic [31:0] d0, d2, d3;
    logic        h0, h2, h3;
`ifdef RIB_RESP_ERR_EN
    logic        e0, e2, e3;
`endif

    always #5 clk = ~clk;

    rib_resp #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we),
        .addr_i(addr), .data_i(wdata), .data_o(d0), .hold_flag_o(h0)
`ifdef RIB_RESP_ERR_EN
        , .err_o(e0)
`endif
    );

    rib_resp #(.WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .req_i(req2), .we_i(we),
        .addr_i(addr), .data_i(wdata), .data_o(d2), .hold_flag_o(h2)
`ifdef RIB_RESP_ERR_EN
        , .err_o(e2)
`endif
    );

    rib_resp #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .req_i(req3), .we_i(we),
        .addr_i(addr), .data_i(wdata), .data_o(d3), .hold_flag_o(h3)
`ifdef RIB_RESP_ERR_EN
        , .err_o(e3)
`endif
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        int          holds;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   hcnt[3];
    bit   ph[3];

    task automatic mon(input int id, input logic h, input logic rq,
                       input logic [31:0] d, input bit comb);
        bit   done;
        exp_t e;
        if (rst !== 1'b1) begin
            checks++;
            if (h !== 1'b0 || d !== 32'h0) begin
                errors++;
                $display("FAIL reset_out dut%0d hold=%b data=%h want hold=0 data=0",
                         id, h, d);
            end
            hcnt[id] = 0;
            ph[id]   = 1'b0;
            return;
        end
        done = comb ? (rq === 1'b1) : (ph[id] && h === 1'b0);
        if (h === 1'b1) hcnt[id]++;
        checks++;
        if (done) begin
            if (sbq.size() == 0 || sbq[0].id != id) begin
                errors++;
                $display("FAIL unexpected_done dut%0d data=%h want no completion",
                         id, d);
            end else begin
                e = sbq.pop_front();
                if (d !== e.data || hcnt[id] != e.holds) begin
                    errors++;
                    $display("FAIL access dut%0d data=%h holds=%0d want data=%h holds=%0d",
                             id, d, hcnt[id], e.data, e.holds);
                end
            end
            hcnt[id] = 0;
        end else if (d !== 32'h0) begin
            errors++;
            $display("FAIL idle_data dut%0d data=%h want 0", id, d);
        end
        ph[id] = (h === 1'b1);
    endtask

    always @(negedge clk) begin
        mon(0, h0, req0, d0, 1'b1);
        mon(1, h2, req2, d2, 1'b0);
        mon(2, h3, req3, d3, 1'b0);
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic set_req(input int id, input logic v);
        case (id)
            0:       req0 = v;
            1:       req2 = v;
            default: req3 = v;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int id, input bit w, input logic [31:0] a,
                      input logic [31:0] dat, input logic [31:0] exp_d,
                      input int holds, input int ncyc);
        sbq.push_back(exp_t'{id, exp_d, holds});
        we    = w;
        addr  = a;
        wdata = dat;
        set_req(id, 1'b1);
        step();
        set_req(id, 1'b0);
        repeat (ncyc - 1) step();
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    logic [31:0] exp_wrap;

    initial begin
        rst   = 1'b0;
        req0  = 1'b0;
        req2  = 1'b0;
        req3  = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
`ifdef RIB_RESP_ERR_EN
        exp_wrap = 32'hDEAD_BEEF;
`else
        exp_wrap = 32'h1234_5678;
`endif
        repeat (3) step();
        rst = 1'b1;
        step();

        // two-cycle responder
        go(1, 1'b1, 32'h1000_0010, 32'h1234_5678, 32'h0, 2, 3);
        go(1, 1'b0, 32'h1000_0010, 32'h0, 32'h1234_5678, 2, 3);
        go(1, 1'b1, 32'h1000_0004, 32'h0BAD_F00D, 32'h0, 2, 3);
        go(1, 1'b1, 32'h1000_0020, 32'h1111_2222, 32'h0, 2, 3);

        // inputs change during WAIT and req stays high through DONE
        sbq.push_back(exp_t'{1, 32'h0BAD_F00D, 2});
        we   = 1'b0;
        addr = 32'h1000_0004;
        req2 = 1'b1;
        step();
        we    = 1'b1;
        addr  = 32'h1000_0020;
        wdata = 32'hDEAD_DEAD;
        step();
        step();
        req2 = 1'b0;
        go(1, 1'b0, 32'h1000_0020, 32'h0, 32'h1111_2222, 2, 3);
        go(1, 1'b0, 32'h1000_0013, 32'h0, 32'h1234_5678, 2, 3);
        go(1, 1'b0, 32'h1000_1010, 32'h0, exp_wrap, 2, 3);

        // reset in the second hold cycle of a write
        we    = 1'b1;
        addr  = 32'h1000_0010;
        wdata = 32'hFFFF_0000;
        req2  = 1'b1;
        step();
        req2 = 1'b0;
        chk("hold_in_wait", {31'h0, h2}, 32'h1);
        rst = 1'b0;
        #1;
        chk("hold_on_rst", {31'h0, h2}, 32'h0);
        step();
        rst = 1'b1;
        step();
        go(1, 1'b0, 32'h1000_0010, 32'h0, 32'h1234_5678, 2, 3);

        // zero-wait responder
        go(0, 1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 32'h0, 0, 1);
        go(0, 1'b0, 32'h1000_0000, 32'h0, 32'hA5A5_A5A5, 0, 1);
        go(0, 1'b1, 32'h1000_0008, 32'h5A5A_1234, 32'h0, 0, 1);
        go(0, 1'b0, 32'h1000_000B, 32'h0, 32'h5A5A_1234, 0, 1);
        step();

        // three-cycle responder, back-to-back with req held high
        go(2, 1'b1, 32'h1000_0040, 32'hCAFE_0001, 32'h0, 3, 4);
        for (int i = 0; i < 3; i++) begin
            sbq.push_back(exp_t'{2, 32'hCAFE_0001, 3});
        end
        we   = 1'b0;
        addr = 32'h1000_0040;
        req3 = 1'b1;
        repeat (12) step();
        req3 = 1'b0;
        repeat (2) step();

`ifdef RIB_RESP_ERR_EN
        pulse_rst();
        chk("err_after_rst", {29'h0, e0, e2, e3}, 32'h0);
        go(1, 1'b0, 32'h0FFF_FFFC, 32'h0, 32'hDEAD_BEEF, 2, 3);
        chk("err_set", {31'h0, e2}, 32'h1);
        go(1, 1'b1, 32'h1000_0018, 32'h7777_8888, 32'h0, 2, 3);
        go(1, 1'b0, 32'h1000_0018, 32'h0, 32'h7777_8888, 2, 3);
        go(1, 1'b1, 32'h1000_0000, 32'h0101_0101, 32'h0, 2, 3);
        go(1, 1'b1, 32'h1000_1000, 32'h9999_9999, 32'h0, 2, 3);
        go(1, 1'b0, 32'h1000_0000, 32'h0, 32'h0101_0101, 2, 3);
        chk("err_sticky", {31'h0, e2}, 32'h1);
        pulse_rst();
        chk("err_cleared", {31'h0, e2}, 32'h0);
`endif

        repeat (2) step();
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
